// File: rtl/work_rx_assembler_pkg.sv
// Shared constants and state encoding for the UART-side work packet assembler.
// The payload length constant is also used by the hashing core.
package work_rx_assembler_pkg;

  // 32-byte midstate followed by the 12-byte header tail
  localparam int unsigned WORK_PAYLOAD_BYTES  = 44;
  localparam logic [7:0]  WORK_SYNC_BYTE      = 8'hA5;
  // 10 ms of silence at 100 MHz
  localparam int unsigned WORK_TIMEOUT_CYCLES = 1000000;

  // Plain vector encoding so older tools and netlist viewers show raw codes
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_LOAD  = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;

  // Increment that sticks at 8'hFF instead of wrapping
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/work_rx_assembler_rx_gap_timer.sv
// rx_gap_timer: counts idle cycles between received bytes and flags the
// cycle on which the gap limit is reached. Reusable by any UART-side block.
module rx_gap_timer
  import work_rx_assembler_pkg::*;
#(
  parameter int unsigned LIMIT = WORK_TIMEOUT_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,    // byte arrived or frame restarted
  input  logic run,      // inside a frame and no byte this cycle
  output logic expired   // gap has reached LIMIT-1 with no byte
);

  localparam int unsigned CW   = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count_reg;

  assign expired = run && !clear && (count_reg == LAST);

  // Gap counter: restart on clear or expiry, otherwise advance while running
  always_ff @(posedge clock) begin
    if (reset || clear || expired) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/work_rx_assembler.sv
// work_rx_assembler: frames the UART byte stream into one work packet
// (sync byte, fixed-length payload, optional XOR checksum) and offers it to
// the miner on a valid/ready handshake. Define WORK_RX_CHECKSUM_EN to enable
// the trailing checksum byte and the CHECK state.
module work_rx_assembler
  import work_rx_assembler_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = WORK_PAYLOAD_BYTES,
  parameter logic [7:0]  SYNC_BYTE      = WORK_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = WORK_TIMEOUT_CYCLES
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  input  logic                       work_ready,
  output logic                       work_valid,
  output logic [8*PAYLOAD_BYTES-1:0] work_data,
  output logic                       busy,
  output logic                       frame_err,
  output logic [15:0]                pkt_count,
  output logic [7:0]                 drop_count
);

  localparam int unsigned DW  = 8 * PAYLOAD_BYTES;
  localparam int unsigned BCW = ($clog2(PAYLOAD_BYTES) > 0) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [BCW-1:0] LAST_IDX = BCW'(PAYLOAD_BYTES - 1);

  state_t         state_reg;
  state_t         state_next;
  logic [BCW-1:0] byte_cnt_reg;
  logic [DW-1:0]  data_reg;
  logic           frame_err_reg;
  logic [15:0]    pkt_count_reg;
  logic [7:0]     drop_count_reg;

  logic in_frame;
  logic sync_hit;
  logic byte_take;
  logic last_byte;
  logic gap_clear;
  logic gap_run;
  logic gap_expired;
  logic csum_bad;
  logic hold_accept;
  logic hold_drop;

  assign in_frame    = (state_reg == ST_LOAD) || (state_reg == ST_CHECK);
  assign sync_hit    = (state_reg == ST_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
  assign byte_take   = (state_reg == ST_LOAD) && rx_valid;
  assign last_byte   = byte_take && (byte_cnt_reg == LAST_IDX);
  assign gap_clear   = sync_hit || (in_frame && rx_valid);
  assign gap_run     = in_frame && !rx_valid;
  assign hold_accept = (state_reg == ST_HOLD) && work_ready;
  assign hold_drop   = (state_reg == ST_HOLD) && rx_valid;

  rx_gap_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (gap_clear),
    .run     (gap_run),
    .expired (gap_expired)
  );

`ifdef WORK_RX_CHECKSUM_EN
  logic [7:0] xor_reg;
  logic       csum_ok;

  assign csum_ok  = (rx_data == xor_reg);
  assign csum_bad = (state_reg == ST_CHECK) && rx_valid && !csum_ok;

  // Running XOR of the payload, restarted by each sync byte
  always_ff @(posedge clock) begin
    if (reset || sync_hit) begin
      xor_reg <= 8'h00;
    end else if (byte_take) begin
      xor_reg <= xor_reg ^ rx_data;
    end
  end
`else
  assign csum_bad = 1'b0;
`endif

  // Next-state selection; a timeout always wins over a byte-driven move
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sync_hit) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (gap_expired) begin
          state_next = ST_IDLE;
        end else if (last_byte) begin
`ifdef WORK_RX_CHECKSUM_EN
          state_next = ST_CHECK;
`else
          state_next = ST_HOLD;
`endif
        end
      end
`ifdef WORK_RX_CHECKSUM_EN
      ST_CHECK: begin
        if (gap_expired) begin
          state_next = ST_IDLE;
        end else if (rx_valid) begin
          state_next = csum_ok ? ST_HOLD : ST_IDLE;
        end
      end
`endif
      ST_HOLD: begin
        if (work_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Payload shift register and byte index; bytes enter at the LSB end so the
  // first payload byte finishes in the top byte (big-endian)
  always_ff @(posedge clock) begin
    if (reset) begin
      byte_cnt_reg <= '0;
      data_reg     <= '0;
    end else begin
      if (sync_hit) begin
        byte_cnt_reg <= '0;
      end else if (byte_take) begin
        byte_cnt_reg <= byte_cnt_reg + BCW'(1);
      end
      if (byte_take) begin
        data_reg <= {data_reg[DW-9:0], rx_data};
      end
    end
  end

  // Single-cycle framing error pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= gap_expired || csum_bad;
    end
  end

  // Status counters: accepted packets wrap, dropped bytes saturate
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count_reg  <= 16'd0;
      drop_count_reg <= 8'd0;
    end else begin
      if (hold_accept) pkt_count_reg  <= pkt_count_reg + 16'd1;
      if (hold_drop)   drop_count_reg <= sat_inc8(drop_count_reg);
    end
  end

  assign work_valid = (state_reg == ST_HOLD);
  assign busy       = in_frame;
  assign work_data  = data_reg;
  assign frame_err  = frame_err_reg;
  assign pkt_count  = pkt_count_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: tb/tb_work_rx_assembler.sv
// Directed bench for work_rx_assembler: a table of whole packets plus
// hand-written sequences for timeout, drops, checksum and mid-packet reset.
// Run with +define+WORK_RX_CHECKSUM_EN to exercise the checksum build.
module tb_work_rx_assembler;

  localparam int PB = 44;
  localparam int T  = 40;          // shortened gap limit for simulation
  localparam int DW = 8 * PB;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          work_ready = 1'b0;
  logic          work_valid;
  logic [DW-1:0] work_data;
  logic          busy;
  logic          frame_err;
  logic [15:0]   pkt_count;
  logic [7:0]    drop_count;

  int tests = 0;
  int fails = 0;
  int gap_err = 0;
  logic [DW-1:0] exp_data;
  logic [15:0]   pkt_exp;

  typedef struct {
    logic        junk_en;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [7:0]  exp_top;
    logic [7:0]  exp_bottom;
    logic [15:0] exp_pkt;
  } pkt_vec_t;

  pkt_vec_t vecs[4];

  work_rx_assembler #(
    .PAYLOAD_BYTES  (PB),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .work_ready (work_ready),
    .work_valid (work_valid),
    .work_data  (work_data),
    .busy       (busy),
    .frame_err  (frame_err),
    .pkt_count  (pkt_count),
    .drop_count (drop_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok   %s", name);
    end
  endtask

  // Called at a negedge; byte is captured on the following posedge
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      if (frame_err) gap_err++;
    end
  endtask

  // Sync plus payload byte i = base + step*i; optional gap after byte 4.
  // Checks work_valid stays low until the final byte and rises right after.
  task automatic send_packet(input logic [7:0] base, input logic [7:0] step,
                             input int gap_len, input string tag);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    send_byte(8'hA5);
    for (int i = 0; i < PB; i++) begin
      b = base + step * 8'(i);
      exp_data = {exp_data[DW-9:0], b};
      x = x ^ b;
`ifndef WORK_RX_CHECKSUM_EN
      if (i == PB - 1) begin
        check({tag, " valid before last"}, {31'd0, work_valid}, 32'd0);
        check({tag, " busy before last"}, {31'd0, busy}, 32'd1);
      end
`endif
      send_byte(b);
      if (i == 4 && gap_len > 0) idle(gap_len);
    end
`ifdef WORK_RX_CHECKSUM_EN
    check({tag, " valid before csum"}, {31'd0, work_valid}, 32'd0);
    send_byte(x);
`endif
    check({tag, " valid after last"}, {31'd0, work_valid}, 32'd1);
    check({tag, " busy in hold"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic handshake(input string tag);
    work_ready = 1'b1;
    @(negedge clock);
    work_ready = 1'b0;
    pkt_exp = pkt_exp + 16'd1;
    check({tag, " valid after ready"}, {31'd0, work_valid}, 32'd0);
    check({tag, " pkt_count"}, {16'd0, pkt_count}, {16'd0, pkt_exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    pkt_exp = 16'd0;
  endtask

  initial begin
    int first_k;
    int highs;
    logic busy_pre;
    logic [DW-1:0] held;

    vecs[0] = '{1'b0, 8'h00, 8'h01, 8'h00, 8'h2B, 16'd1};
    vecs[1] = '{1'b1, 8'h10, 8'h02, 8'h10, 8'h66, 16'd2};
    vecs[2] = '{1'b0, 8'hA5, 8'h00, 8'hA5, 8'hA5, 16'd3};
    vecs[3] = '{1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hD4, 16'd4};
    exp_data = '0;
    pkt_exp  = 16'd0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("reset work_valid", {31'd0, work_valid}, 32'd0);
    check_data("reset work_data", work_data, '0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset frame_err", {31'd0, frame_err}, 32'd0);
    check("reset pkt_count", {16'd0, pkt_count}, 32'd0);
    check("reset drop_count", {24'd0, drop_count}, 32'd0);

    // Table of whole packets
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].junk_en) begin
        send_byte(8'h11);
        send_byte(8'h22);
        check($sformatf("vec%0d junk ignored", v), {31'd0, busy}, 32'd0);
      end
      send_packet(vecs[v].base, vecs[v].step, 0, $sformatf("vec%0d", v));
      repeat (3) @(negedge clock);
      check($sformatf("vec%0d top byte", v), {24'd0, work_data[DW-1 -: 8]}, {24'd0, vecs[v].exp_top});
      check($sformatf("vec%0d bottom byte", v), {24'd0, work_data[7:0]}, {24'd0, vecs[v].exp_bottom});
      check_data($sformatf("vec%0d payload held", v), work_data, exp_data);
      check($sformatf("vec%0d pkt before ready", v), {16'd0, pkt_count}, {16'd0, vecs[v].exp_pkt - 16'd1});
      handshake($sformatf("vec%0d", v));
      check($sformatf("vec%0d pkt table", v), {16'd0, pkt_count}, {16'd0, vecs[v].exp_pkt});
    end

    // Drops in HOLD, including a sync byte on the handshake cycle
    send_packet(8'h40, 8'h01, 0, "drop");
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    check("drop three", {24'd0, drop_count}, 32'd3);
    work_ready = 1'b1;
    rx_valid   = 1'b1;
    rx_data    = 8'hA5;
    @(negedge clock);
    work_ready = 1'b0;
    rx_valid   = 1'b0;
    pkt_exp    = pkt_exp + 16'd1;
    check("drop on handshake", {24'd0, drop_count}, 32'd4);
    check("handshake valid low", {31'd0, work_valid}, 32'd0);
    check("handshake pkt", {16'd0, pkt_count}, {16'd0, pkt_exp});
    @(negedge clock);
    check("dropped sync not framed", {31'd0, busy}, 32'd0);

    // Gap one cycle short of the limit must not time out
    gap_err = 0;
    send_packet(8'h70, 8'h05, T - 1, "nearmiss");
    check("nearmiss no frame_err", gap_err, 32'd0);
    handshake("nearmiss");

    // Timeout mid-packet: single pulse exactly T idle cycles after last byte
    send_byte(8'hA5);
    for (int i = 0; i < 10; i++) send_byte(8'(i));
    first_k  = 0;
    highs    = 0;
    busy_pre = 1'b0;
    for (int c = 1; c <= T + 5; c++) begin
      @(negedge clock);
      if (c == T - 1) busy_pre = busy;
      if (frame_err) begin
        highs++;
        if (first_k == 0) first_k = c;
      end
    end
    check("timeout busy before expiry", {31'd0, busy_pre}, 32'd1);
    check("timeout cycle", first_k, T);
    check("timeout pulse width", highs, 32'd1);
    check("timeout busy", {31'd0, busy}, 32'd0);
    check("timeout pkt unchanged", {16'd0, pkt_count}, {16'd0, pkt_exp});
    send_packet(8'h20, 8'h03, 0, "after timeout");
    handshake("after timeout");

`ifdef WORK_RX_CHECKSUM_EN
    // Good checksum: 44 x 01 XORs to 00
    send_byte(8'hA5);
    for (int i = 0; i < PB; i++) send_byte(8'h01);
    send_byte(8'h00);
    check("csum ok valid", {31'd0, work_valid}, 32'd1);
    handshake("csum ok");
    // Bad checksum
    send_byte(8'hA5);
    for (int i = 0; i < PB; i++) send_byte(8'h01);
    send_byte(8'hFF);
    check("csum bad frame_err", {31'd0, frame_err}, 32'd1);
    check("csum bad valid", {31'd0, work_valid}, 32'd0);
    check("csum bad busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    check("csum bad pulse ends", {31'd0, frame_err}, 32'd0);
    check("csum bad pkt", {16'd0, pkt_count}, {16'd0, pkt_exp});
`endif

    // Drop counter saturation with payload held stable
    do_reset();
    send_packet(8'h30, 8'h03, 0, "sat");
    held = exp_data;
    for (int i = 0; i < 300; i++) send_byte(8'(i));
    check("sat drop_count", {24'd0, drop_count}, 32'd255);
    check("sat valid", {31'd0, work_valid}, 32'd1);
    check_data("sat payload unchanged", work_data, held);
    handshake("sat");

    // Reset in the middle of a packet
    send_byte(8'hA5);
    for (int i = 0; i < 20; i++) send_byte(8'h5A);
    do_reset();
    check("midreset work_valid", {31'd0, work_valid}, 32'd0);
    check_data("midreset work_data", work_data, '0);
    check("midreset busy", {31'd0, busy}, 32'd0);
    check("midreset frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset pkt_count", {16'd0, pkt_count}, 32'd0);
    check("midreset drop_count", {24'd0, drop_count}, 32'd0);
    send_packet(8'h01, 8'h07, 0, "post reset");
    check_data("post reset payload", work_data, exp_data);
    handshake("post reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
